// File: rtl/proc_pkg.sv
// Shared processor constants: opcode field values used by the fetch unit and the CU,
// plus the 3-bit state encoding of the fetch sequencer.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_IMM   = 3'd3,
    S_IMLD  = 3'd4,
    S_ISSUE = 3'd5,
    S_WAIT  = 3'd6
  } fetch_state_t;

  // Words consumed by an instruction: mvi carries its immediate in the next ROM slot.
  function automatic logic [1:0] instr_len(input logic [2:0] op);
    return (op == OP_MVI) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/done_watchdog.sv
// Counts cycles spent waiting for Done; expired is combinational and fires on the enabled cycle
// whose increment would bring the count to TIMEOUT-1. clr has priority over en.
module done_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 2));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue sequencer feeding the 9-bit control unit from a synchronous-read ROM.
// First Run 3 cycles after Start (5 for mvi); stalls in WAIT on Done, bounded by the watchdog.
module instr_fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Err
);

  import proc_pkg::*;

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [DATA_W-1:0] ir_nx, din_nx;
  logic              halted_nx, err_nx;
  logic              wd_clr, wd_en, wd_expired;
  logic [2:0]        ld_op, ir_op;

  assign ld_op = mem_rdata[DATA_W-1 -: 3];
  assign ir_op = IR[DATA_W-1 -: 3];

  done_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      PC     <= '0;
      IR     <= '0;
      DIN    <= '0;
      Halted <= 1'b0;
      Err    <= 1'b0;
    end else begin
      state  <= state_nx;
      PC     <= pc_nx;
      IR     <= ir_nx;
      DIN    <= din_nx;
      Halted <= halted_nx;
      Err    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = PC;
    ir_nx     = IR;
    din_nx    = DIN;
    halted_nx = Halted;
    err_nx    = Err;
    mem_re    = 1'b0;
    mem_addr  = PC;
    Run       = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          pc_nx     = '0;
          halted_nx = 1'b0;
          err_nx    = 1'b0;
          state_nx  = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_re   = 1'b1;
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        ir_nx = mem_rdata;
        case (ld_op)
          OP_MVI:                state_nx = S_IMM;
          OP_MV, OP_ADD, OP_SUB: state_nx = S_ISSUE;
          OP_HALT: begin
            halted_nx = 1'b1;
            state_nx  = S_IDLE;
          end
          default: begin
            pc_nx    = PC + ADDR_W'(1);
            state_nx = S_FETCH;
          end
        endcase
      end
      S_IMM: begin
        // Immediate sits in the next slot; address arithmetic wraps naturally at 2**ADDR_W.
        mem_re   = 1'b1;
        mem_addr = PC + ADDR_W'(1);
        state_nx = S_IMLD;
      end
      S_IMLD: begin
        din_nx   = mem_rdata;
        state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        Run      = 1'b1;
        wd_clr   = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Done takes precedence over a watchdog expiry in the same cycle.
        if (Done) begin
          pc_nx    = PC + ADDR_W'(instr_len(ir_op));
          state_nx = S_FETCH;
        end else begin
          wd_en = 1'b1;
          if (wd_expired) begin
            err_nx   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign Busy = (state != S_IDLE);

endmodule
